queue_executor: RTL and testbench
=================================

QUEUE_EXECUTOR -- requirements
Module: queue_executor

Interface
REQ-001 The interface SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-004 Port cmd_valid SHALL be: input, 1 bit, an arithmetic command is offered.
REQ-005 Port cmd_op SHALL be: input, 2 bits, ALU operation: 00 ADD, 01 SUB, 10 MUL, 11 AND.
REQ-006 Port cmd_ready SHALL be: output, 1 bit, the executor accepts a command this cycle.
REQ-007 Port top_conc SHALL be: input, 16 bits, the queue's two front entries; [15:8] is operand A (front), [7:0] is operand B.
REQ-008 Port pos_back SHALL be: input, 3 bits, the queue occupancy (0..4).
REQ-009 Port opcode SHALL be: output, 2 bits, the queue command: 00 NOP, 01 POP1, 10 PUSH, 11 POP2.
REQ-010 Port back SHALL be: output, 8 bits, the value pushed when opcode is PUSH.
REQ-011 Port result SHALL be: output, 8 bits, the last computed result.
REQ-012 Port flag SHALL be: output, 1 bit, the flag for the last result: ADD carry, SUB borrow, MUL product[15:8] nonzero, AND always 0.
REQ-013 Port done SHALL be: output, 1 bit, a one-cycle pulse when result and flag are valid.
REQ-014 Port err SHALL be: output, 1 bit, a one-cycle pulse on queue underflow (command rejected).

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, POP, PUSH, DONE and ERR; the encoding is held in the shared header.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1, cmd_op is registered, and the FSM moves IDLE->LOAD.
REQ-017 In LOAD, if pos_back < 2, the FSM SHALL move to ERR; otherwise it SHALL capture top_conc into the operand registers and move to POP.
REQ-018 In POP, opcode SHALL be 11 for exactly one cycle, and the ALU result SHALL be registered that cycle; then the FSM moves to PUSH.
REQ-019 In PUSH, opcode SHALL be 10 and back SHALL equal the registered result for exactly one cycle; then the FSM moves to DONE.
REQ-020 In DONE, done SHALL be 1, result and flag SHALL be updated and visible, and the FSM returns to IDLE.
REQ-021 In ERR, err SHALL be 1, opcode SHALL be 00, result and flag SHALL hold their previous values, and the FSM returns to IDLE.
REQ-022 In IDLE, LOAD, DONE and ERR, opcode SHALL be 00 and back SHALL be 0.
REQ-023 Latency: done SHALL assert 4 cycles after the accept edge, and err 2 cycles after it; throughput is one command per 5 cycles.
REQ-024 Arithmetic SHALL be mod 256 on 8-bit operands: SUB=A-B with borrow=(A<B); MUL keeps product[7:0].
REQ-025 The queue SHALL never overflow: net occupancy change per command is -1, so no full check is required.
REQ-026 cmd_valid held high in non-IDLE states SHALL be ignored; cmd_op changes after accept SHALL have no effect.
REQ-027 pos_back values above 4 SHALL be treated as >= 2 (no special error).

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE, opcode 00, back 0, result 0, flag 0, done 0, err 0, and cmd_ready SHALL read 1 once rst deasserts.
REQ-029 Reset asserted in any state, including mid-POP or mid-PUSH, SHALL immediately force opcode 00 and abandon the command with no done and no err.

Structure
REQ-030 Queue opcode constants, ALU cmd_op constants and FSM state encodings SHALL live in the shared header queue_defs.vh, which is also used by queue and queue_controller.
REQ-031 A combinational sub-module queue_exec_alu (inputs A, B, op; outputs result[7:0], flag) SHALL hold all arithmetic.

Verification
REQ-032 Queue {5,3}, ADD -> opcode 11 then 10 with back=8, done with result=8, flag=0, pos_back 2->1.
REQ-033 Queue {3,5}, SUB -> result=254 (0xFE), flag=1.
REQ-034 Queue {20,13}, MUL -> result=4 (260 mod 256), flag=1; then {0xF0,0x3C}, AND -> 0x30, flag=0.
REQ-035 pos_back=1, any cmd -> err pulse 2 cycles after accept, opcode stays 00, result unchanged.
REQ-036 rst pulsed during POP -> opcode 00 immediately, no done, cmd_ready=1 after release; the next ADD {1,1} yields result 2.
REQ-037 cmd_valid held high continuously -> accepts spaced exactly 5 cycles apart, cmd_ready high only in IDLE.

Source files
------------

// File: rtl/queue_executor_pkg.sv
// Shared encodings for the queue executor: queue commands, ALU operations
// and executor FSM states.
package queue_executor_pkg;

    typedef enum logic [1:0] {
        Q_NOP  = 2'b00,
        Q_POP1 = 2'b01,
        Q_PUSH = 2'b10,
        Q_POP2 = 2'b11
    } queue_op_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_AND = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_POP  = 3'd2,
        S_PUSH = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } exec_state_t;

    // A binary operation needs both front entries present in the queue.
    localparam logic [2:0] MIN_OPERANDS = 3'd2;

endpackage

// File: rtl/queue_executor_alu.sv
// Combinational 8-bit ALU for the queue executor; results are mod 256 and
// the flag carries the overflow information lost by truncation.
module queue_exec_alu
    import queue_executor_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] result,
    output logic       flag
);

    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [15:0] prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = {8'h00, a} * {8'h00, b};

    always_comb begin
        result = 8'h00;
        flag   = 1'b0;
        case (alu_op_t'(op))
            ALU_ADD: begin
                result = sum[7:0];
                flag   = sum[8];
            end
            ALU_SUB: begin
                result = diff[7:0];
                flag   = (a < b);
            end
            ALU_MUL: begin
                result = prod[7:0];
                flag   = |prod[15:8];
            end
            ALU_AND: begin
                result = a & b;
                flag   = 1'b0;
            end
            default: begin
                result = 8'h00;
                flag   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/queue_executor.sv
// Executes one arithmetic command against the two front queue entries:
// pop both, compute, push the result back, then report done (or err on underflow).
module queue_executor
    import queue_executor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic [15:0] top_conc,
    input  logic [2:0]  pos_back,
    output logic [1:0]  opcode,
    output logic [7:0]  back,
    output logic [7:0]  result,
    output logic        flag,
    output logic        done,
    output logic        err
);

    exec_state_t state;
    logic [1:0]  op_reg;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [7:0]  res_reg;
    logic        flag_reg;
    logic [7:0]  alu_res;
    logic        alu_flag;

    queue_exec_alu u_alu (
        .a      (opa),
        .b      (opb),
        .op     (op_reg),
        .result (alu_res),
        .flag   (alu_flag)
    );

    assign cmd_ready = (state == S_IDLE);

    // Outputs are registered alongside the state they belong to, so each one
    // is set on the edge that enters its state and cleared on the edge leaving it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_reg   <= 2'b00;
            opa      <= 8'h00;
            opb      <= 8'h00;
            res_reg  <= 8'h00;
            flag_reg <= 1'b0;
            opcode   <= Q_NOP;
            back     <= 8'h00;
            result   <= 8'h00;
            flag     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            opcode <= Q_NOP;
            back   <= 8'h00;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_reg <= cmd_op;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pos_back < MIN_OPERANDS) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        opa    <= top_conc[15:8];
                        opb    <= top_conc[7:0];
                        opcode <= Q_POP2;
                        state  <= S_POP;
                    end
                end
                S_POP: begin
                    res_reg  <= alu_res;
                    flag_reg <= alu_flag;
                    opcode   <= Q_PUSH;
                    back     <= alu_res;
                    state    <= S_PUSH;
                end
                S_PUSH: begin
                    result <= res_reg;
                    flag   <= flag_reg;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_executor.sv
// Directed self-checking bench for queue_executor with a small behavioural
// queue that reacts to the executor's opcode/back outputs.
module tb_queue_executor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic        cmd_ready;
    logic [15:0] top_conc;
    logic [2:0]  pos_back;
    logic [1:0]  opcode;
    logic [7:0]  back;
    logic [7:0]  result;
    logic        flag;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    // queue model
    logic [7:0] q [0:3];
    logic [2:0] cnt;
    logic [7:0] ld_q [0:3];
    logic [2:0] ld_n = 3'd0;
    logic       ld_go = 1'b0;
    logic       pos_ovr_en = 1'b0;
    logic [2:0] pos_ovr = 3'd0;

    logic [7:0] tbl_a  [0:6] = '{8'd5, 8'd3, 8'd20, 8'hF0, 8'd7, 8'd15, 8'd200};
    logic [7:0] tbl_b  [0:6] = '{8'd3, 8'd5, 8'd13, 8'h3C, 8'd7, 8'd17, 8'd100};
    logic [1:0] tbl_op [0:6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [7:0] tbl_r  [0:6] = '{8'd8, 8'hFE, 8'd4, 8'h30, 8'h00, 8'hFF, 8'h2C};
    logic       tbl_f  [0:6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    queue_executor dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .top_conc  (top_conc),
        .pos_back  (pos_back),
        .opcode    (opcode),
        .back      (back),
        .result    (result),
        .flag      (flag),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign top_conc = {q[0], q[1]};
    assign pos_back = pos_ovr_en ? pos_ovr : cnt;

    always @(posedge clk) begin
        if (ld_go) begin
            q   <= ld_q;
            cnt <= ld_n;
        end else if (opcode == 2'b11) begin
            q[0] <= q[2];
            q[1] <= q[3];
            q[2] <= 8'h00;
            q[3] <= 8'h00;
            cnt  <= (cnt >= 3'd2) ? cnt - 3'd2 : 3'd0;
        end else if (opcode == 2'b10) begin
            if (cnt < 3'd4) q[cnt[1:0]] <= back;
            cnt <= cnt + 3'd1;
        end
    end

    task automatic load_queue(input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3,
                              input logic [2:0] n);
        ld_q[0] = a0;
        ld_q[1] = a1;
        ld_q[2] = a2;
        ld_q[3] = a3;
        ld_n    = n;
        ld_go   = 1'b1;
        @(negedge clk);
        ld_go   = 1'b0;
    endtask

    // Offers a command in the current (IDLE) cycle, then scrambles cmd_op.
    task automatic accept_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({opcode, back, result, flag, done, err} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {opcode, back, result, flag, done, err});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_alu_ops;
        for (int i = 0; i < 7; i++) begin
            load_queue(tbl_a[i], tbl_b[i], 8'h00, 8'h00, 3'd2);
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL alu%0d_ready: got %b expected 1", i, cmd_ready);
            end
            accept_cmd(tbl_op[i]);
            checks++;
            if ({cmd_ready, opcode} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL alu%0d_load: got %b expected 000", i, {cmd_ready, opcode});
            end
            @(negedge clk);
            checks++;
            if ({opcode, back} !== {2'b11, 8'h00}) begin
                errors++;
                $display("[TB] FAIL alu%0d_pop: got %h expected %h", i, {opcode, back}, {2'b11, 8'h00});
            end
            @(negedge clk);
            checks++;
            if ({opcode, back} !== {2'b10, tbl_r[i]}) begin
                errors++;
                $display("[TB] FAIL alu%0d_push: got %h expected %h", i, {opcode, back}, {2'b10, tbl_r[i]});
            end
            @(negedge clk);
            checks++;
            if ({done, result, flag, opcode} !== {1'b1, tbl_r[i], tbl_f[i], 2'b00}) begin
                errors++;
                $display("[TB] FAIL alu%0d_done: got %h expected %h", i,
                         {done, result, flag, opcode}, {1'b1, tbl_r[i], tbl_f[i], 2'b00});
            end
            checks++;
            if (pos_back !== 3'd1) begin
                errors++;
                $display("[TB] FAIL alu%0d_occupancy: got %0d expected 1", i, pos_back);
            end
            @(negedge clk);
            checks++;
            if ({done, cmd_ready} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL alu%0d_idle: got %b expected 01", i, {done, cmd_ready});
            end
        end
    endtask

    task automatic test_underflow;
        for (int n = 0; n < 2; n++) begin
            load_queue(8'd9, 8'd0, 8'd0, 8'd0, 3'(n));
            accept_cmd(2'b10);
            checks++;
            if ({err, opcode} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL uf%0d_load: got %b expected 000", n, {err, opcode});
            end
            @(negedge clk);
            checks++;
            if ({err, done, opcode, result, flag} !== {1'b1, 1'b0, 2'b00, 8'h2C, 1'b1}) begin
                errors++;
                $display("[TB] FAIL uf%0d_err: got %h expected %h", n,
                         {err, done, opcode, result, flag}, {1'b1, 1'b0, 2'b00, 8'h2C, 1'b1});
            end
            @(negedge clk);
            checks++;
            if ({err, done, cmd_ready, pos_back} !== {3'b001, 3'(n)}) begin
                errors++;
                $display("[TB] FAIL uf%0d_after: got %b expected %b", n,
                         {err, done, cmd_ready, pos_back}, {3'b001, 3'(n)});
            end
        end
    endtask

    task automatic test_pos_above_four;
        load_queue(8'd9, 8'd4, 8'd0, 8'd0, 3'd2);
        pos_ovr_en = 1'b1;
        pos_ovr    = 3'd5;
        accept_cmd(2'b00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done, err, result, flag} !== {2'b10, 8'd13, 1'b0}) begin
            errors++;
            $display("[TB] FAIL pos5_done: got %h expected %h", {done, err, result, flag}, {2'b10, 8'd13, 1'b0});
        end
        pos_ovr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pop;
        logic seen;
        load_queue(8'd6, 8'd6, 8'd0, 8'd0, 3'd2);
        accept_cmd(2'b00);
        @(negedge clk);
        checks++;
        if (opcode !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rstpop_in_pop: got %b expected 11", opcode);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({opcode, back, done, err} !== 12'h0) begin
            errors++;
            $display("[TB] FAIL rstpop_immediate: got %h expected 0", {opcode, back, done, err});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, result} !== {1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL rstpop_release: got %h expected %h", {cmd_ready, result}, {1'b1, 8'h00});
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstpop_abandoned: got pulse=%b expected 0", seen);
        end
        load_queue(8'd1, 8'd1, 8'd0, 8'd0, 3'd2);
        accept_cmd(2'b00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done, result, flag} !== {1'b1, 8'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rstpop_next_add: got %h expected %h", {done, result, flag}, {1'b1, 8'd2, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_res [0:2];
        logic       exp_rdy;
        exp_res[0] = 8'd3;
        exp_res[1] = 8'd7;
        exp_res[2] = 8'd10;
        load_queue(8'd1, 8'd2, 8'd3, 8'd4, 3'd4);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        for (int c = 0; c < 15; c++) begin
            exp_rdy = (c % 5 == 0);
            checks++;
            if (cmd_ready !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL b2b_ready_c%0d: got %b expected %b", c, cmd_ready, exp_rdy);
            end
            if (c % 5 == 4) begin
                checks++;
                if ({done, result} !== {1'b1, exp_res[c / 5]}) begin
                    errors++;
                    $display("[TB] FAIL b2b_done_c%0d: got %h expected %h", c, {done, result}, {1'b1, exp_res[c / 5]});
                end
            end
            if (c == 14) cmd_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({cmd_ready, pos_back} !== {1'b1, 3'd1}) begin
            errors++;
            $display("[TB] FAIL b2b_end: got %b expected %b", {cmd_ready, pos_back}, {1'b1, 3'd1});
        end
    endtask

    initial begin
        q[0] = 8'h00;
        q[1] = 8'h00;
        q[2] = 8'h00;
        q[3] = 8'h00;
        cnt  = 3'd0;
        $display("[TB] starting queue_executor bench");
        test_reset;
        test_alu_ops;
        test_underflow;
        test_pos_above_four;
        test_reset_mid_pop;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
